elevator_request_queue: RTL and testbench

//  Upstream stage of the 4-floor elevator controller: captures asynchronous call-button presses,

---
 rtl/elevator_request_queue_if.sv | 39 +++
 rtl/elevator_request_queue.sv | 174 +++++++++++++++++
 tb/tb_elevator_request_queue.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/elevator_request_queue_if.sv
// Handshake bundle between the call-button panel, the car position lines of
// the elevator controller and the request queue that sits between them.
interface elevator_request_queue_if;
  // raw call buttons, asynchronous level inputs
  logic       btn_ground;
  logic       btn_first;
  logic       btn_second;
  logic       btn_third;
  // car position, one-hot from the controller's op_* outputs
  logic       at_ground;
  logic       at_first;
  logic       at_second;
  logic       at_third;
  // one-hot floor request into the controller's ip_* inputs
  logic       req_ground;
  logic       req_first;
  logic       req_second;
  logic       req_third;
  // status
  logic [3:0] pending;
  logic       busy;
  logic       dir_up;

  // environment side: drives buttons and position, observes requests
  modport master (
    output btn_ground, btn_first, btn_second, btn_third,
    output at_ground, at_first, at_second, at_third,
    input  req_ground, req_first, req_second, req_third,
    input  pending, busy, dir_up
  );

  // queue side
  modport slave (
    input  btn_ground, btn_first, btn_second, btn_third,
    input  at_ground, at_first, at_second, at_third,
    output req_ground, req_first, req_second, req_third,
    output pending, busy, dir_up
  );
endinterface

// File: rtl/elevator_request_queue.sv
// Request queue for a 4-floor elevator: synchronizes call buttons, holds
// pending calls and hands them to the controller one at a time in SCAN order,
// dwelling at each served floor before moving on.
module elevator_request_queue #(
  parameter int SYNC_STAGES  = 2,
  parameter int DWELL_CYCLES = 8,
  parameter int CNT_W        = 4
) (
  input logic                     clk,
  input logic                     rst,
  elevator_request_queue_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DWELL} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       pending_reg, pending_next;
  logic [3:0]       req_reg, req_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             dir_up_reg, dir_up_next;

  logic [3:0] btn_raw;
  logic [3:0] btn_rise;
  logic [3:0] cur_oh;
  logic       cur_valid;
  logic [1:0] cur_idx;
  logic [3:0] above_mask, below_mask;
  logic [3:0] pend_above, pend_below;
  logic [3:0] up_oh, dn_oh;
  logic [1:0] up_idx, dn_idx;
  logic       has_up, has_dn, go_up;
  logic [3:0] clr_mask;

  assign btn_raw = {bus.btn_third, bus.btn_second, bus.btn_first, bus.btn_ground};
  assign cur_oh  = {bus.at_third, bus.at_second, bus.at_first, bus.at_ground};

  // index of the single set bit (callers guarantee one-hot or ignore result)
  function automatic logic [1:0] oh2idx(input logic [3:0] v);
    oh2idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) oh2idx = 2'(i);
    end
  endfunction

  // highest set bit as a one-hot vector
  function automatic logic [3:0] highest_oh(input logic [3:0] v);
    highest_oh = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) highest_oh = 4'(1 << i);
    end
  endfunction

  // Per-button synchronizer chain plus one history flop for rise detection;
  // a held button therefore counts as a single press.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;
      logic                   hist_reg;

      // shift the raw level through the synchronizer and remember last output
      always_ff @(posedge clk) begin
        if (rst) begin
          chain_reg <= '0;
          hist_reg  <= 1'b0;
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-2:0], btn_raw[gi]};
          hist_reg  <= chain_reg[SYNC_STAGES-1];
        end
      end

      assign btn_rise[gi]   = chain_reg[SYNC_STAGES-1] & ~hist_reg;
      assign above_mask[gi] = cur_valid && (2'(gi) > cur_idx);
      assign below_mask[gi] = cur_valid && (2'(gi) < cur_idx);
    end
  endgenerate

  assign cur_valid  = $onehot(cur_oh);
  assign cur_idx    = oh2idx(cur_oh);
  assign pend_above = pending_reg & above_mask;
  assign pend_below = pending_reg & below_mask;
  assign has_up     = |pend_above;
  assign has_dn     = |pend_below;
  // nearest call above is the lowest bit, nearest below is the highest bit
  assign up_oh      = pend_above & (~pend_above + 4'd1);
  assign dn_oh      = highest_oh(pend_below);
  assign up_idx     = oh2idx(up_oh);
  assign dn_idx     = oh2idx(dn_oh);
  // with calls on both sides pick the closer one, ties go up
  assign go_up      = (up_idx - cur_idx) <= (cur_idx - dn_idx);

  // SCAN decision, registered request and dwell bookkeeping; nothing moves
  // while the position lines are not exactly one-hot
  always_comb begin
    state_next  = state_reg;
    req_next    = req_reg;
    cnt_next    = cnt_reg;
    dir_up_next = dir_up_reg;
    clr_mask    = 4'd0;
    if (cur_valid) begin
      case (state_reg)
        IDLE: begin
          if (pending_reg[cur_idx])  state_next = DWELL;
          else if (has_up && has_dn) state_next = go_up ? MOVE_UP : MOVE_DOWN;
          else if (has_up)           state_next = MOVE_UP;
          else if (has_dn)           state_next = MOVE_DOWN;
        end
        MOVE_UP: begin
          if (pending_reg[cur_idx]) state_next = DWELL;
          else if (!has_up)         state_next = IDLE;
        end
        MOVE_DOWN: begin
          if (pending_reg[cur_idx]) state_next = DWELL;
          else if (!has_dn)         state_next = IDLE;
        end
        DWELL: begin
          if (cnt_reg != '0)                   state_next = DWELL;
          else if (dir_up_reg ? has_up : has_dn) state_next = dir_up_reg ? MOVE_UP : MOVE_DOWN;
          else if (dir_up_reg ? has_dn : has_up) state_next = dir_up_reg ? MOVE_DOWN : MOVE_UP;
          else                                   state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase

      case (state_next)
        MOVE_UP: begin
          req_next    = up_oh;
          dir_up_next = 1'b1;
        end
        MOVE_DOWN: begin
          req_next    = dn_oh;
          dir_up_next = 1'b0;
        end
        DWELL:   req_next = cur_oh;
        default: req_next = 4'd0;
      endcase

      if (state_reg != DWELL && state_next == DWELL) cnt_next = CNT_W'(DWELL_CYCLES - 1);
      else if (state_reg == DWELL && cnt_reg != '0)  cnt_next = cnt_reg - CNT_W'(1);

      // the floor being dwelt at is served: its call is dropped, even a fresh press
      if (state_reg == DWELL || state_next == DWELL) clr_mask = cur_oh;
    end
  end

  // clear beats set on the same floor
  assign pending_next = (pending_reg | btn_rise) & ~clr_mask;

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      pending_reg <= 4'd0;
      req_reg     <= 4'd0;
      cnt_reg     <= '0;
      dir_up_reg  <= 1'b1;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      req_reg     <= req_next;
      cnt_reg     <= cnt_next;
      dir_up_reg  <= dir_up_next;
    end
  end

  assign bus.req_ground = req_reg[0];
  assign bus.req_first  = req_reg[1];
  assign bus.req_second = req_reg[2];
  assign bus.req_third  = req_reg[3];
  assign bus.pending    = pending_reg;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.dir_up     = dir_up_reg;

endmodule

// File: tb/tb_elevator_request_queue.sv
// Bench for the elevator request queue: directed scenarios with literal
// expectations, then a random phase with a simple car that chases the
// request, all checked every cycle against a floor-level reference model.
module tb_elevator_request_queue;
  localparam int S = 2;
  localparam int D = 8;

  localparam int M_IDLE  = 0;
  localparam int M_UP    = 1;
  localparam int M_DOWN  = 2;
  localparam int M_DWELL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  elevator_request_queue_if bus();

  elevator_request_queue #(.SYNC_STAGES(S), .DWELL_CYCLES(D), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // reference model state
  bit       m_ready = 0;
  bit       m_pend[4];
  int       m_mode;
  int       m_cnt;
  int       m_req;   // served floor, -1 when no request
  bit       m_dir;
  logic [3:0] hist[$];

  function automatic logic [3:0] btn_vec();
    return {bus.btn_third, bus.btn_second, bus.btn_first, bus.btn_ground};
  endfunction

  function automatic logic [3:0] at_vec();
    return {bus.at_third, bus.at_second, bus.at_first, bus.at_ground};
  endfunction

  function automatic logic [3:0] req_vec();
    return {bus.req_third, bus.req_second, bus.req_first, bus.req_ground};
  endfunction

  function automatic logic [3:0] m_req_vec();
    logic [3:0] v;
    v = 4'd0;
    if (m_req >= 0) v[m_req] = 1'b1;
    return v;
  endfunction

  function automatic logic [3:0] m_pend_vec();
    logic [3:0] v;
    for (int f = 0; f < 4; f++) v[f] = m_pend[f];
    return v;
  endfunction

  task automatic set_btn(input logic [3:0] v);
    bus.btn_ground = v[0];
    bus.btn_first  = v[1];
    bus.btn_second = v[2];
    bus.btn_third  = v[3];
  endtask

  task automatic set_at(input logic [3:0] v);
    bus.at_ground = v[0];
    bus.at_first  = v[1];
    bus.at_second = v[2];
    bus.at_third  = v[3];
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
  endtask

  // literal expectation applied to both the design and the model
  task automatic lit(input string name, input logic [3:0] dut_val,
                     input logic [3:0] mdl_val, input logic [3:0] exp);
    chk(name, dut_val, exp);
    chk({name, "_model"}, mdl_val, exp);
    $display("lit %-16s dut=%b model=%b want=%b", name, dut_val, mdl_val, exp);
  endtask

  // Reference model: per clock edge, apply the SCAN rules at floor level.
  initial begin
    logic [3:0] b, a, rise;
    int c, na, nb, want, other, was_mode;
    bit nxt_pend[4];
    forever begin
      @(posedge clk);
      b = btn_vec();
      a = at_vec();
      if (rst) begin
        hist.delete();
        for (int i = 0; i <= S; i++) hist.push_back(4'd0);
        for (int f = 0; f < 4; f++) m_pend[f] = 0;
        m_mode  = M_IDLE;
        m_cnt   = 0;
        m_req   = -1;
        m_dir   = 1;
        m_ready = 1;
      end else if (m_ready) begin
        // a press reaches the queue S+1 edges after it is first sampled
        rise = hist[S-1] & ~hist[S];
        for (int f = 0; f < 4; f++) nxt_pend[f] = m_pend[f] | rise[f];
        if ($countones(a) == 1) begin
          c = 0;
          for (int f = 0; f < 4; f++) if (a[f]) c = f;
          na = -1;
          for (int f = 3; f > c; f--) if (m_pend[f]) na = f;
          nb = -1;
          for (int f = 0; f < c; f++) if (m_pend[f]) nb = f;
          was_mode = m_mode;
          if (m_mode != M_DWELL && m_pend[c]) begin
            m_mode = M_DWELL; m_cnt = D - 1; m_req = c;
          end else if (m_mode == M_IDLE) begin
            if (na >= 0 && (nb < 0 || (na - c) <= (c - nb))) begin
              m_mode = M_UP; m_dir = 1; m_req = na;
            end else if (nb >= 0) begin
              m_mode = M_DOWN; m_dir = 0; m_req = nb;
            end
          end else if (m_mode == M_UP) begin
            if (na >= 0) m_req = na;
            else begin m_mode = M_IDLE; m_req = -1; end
          end else if (m_mode == M_DOWN) begin
            if (nb >= 0) m_req = nb;
            else begin m_mode = M_IDLE; m_req = -1; end
          end else begin
            if (m_cnt > 0) begin
              m_cnt--; m_req = c;
            end else begin
              want  = m_dir ? na : nb;
              other = m_dir ? nb : na;
              if (want < 0 && other >= 0) begin m_dir = !m_dir; want = other; end
              if (want >= 0) begin
                m_mode = (want > c) ? M_UP : M_DOWN;
                m_req  = want;
              end else begin
                m_mode = M_IDLE; m_req = -1;
              end
            end
          end
          if (was_mode == M_DWELL || m_mode == M_DWELL) nxt_pend[c] = 0;
        end
        for (int f = 0; f < 4; f++) m_pend[f] = nxt_pend[f];
        void'(hist.pop_back());
        hist.push_front(b);
      end
    end
  end

  // Cycle compare of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_ready) begin
        chk("req",     req_vec(),          m_req_vec());
        chk("pending", bus.pending,        m_pend_vec());
        chk("busy",    {3'd0, bus.busy},   {3'd0, m_mode != M_IDLE});
        chk("dir_up",  {3'd0, bus.dir_up}, {3'd0, m_dir});
      end
    end
  end

  // Stimulus
  initial begin
    int car, mv, tgt;
    logic [3:0] btn_lvl;
    set_btn(4'd0);
    set_at(4'b0001);
    rst = 1'b1;
    step(3);
    lit("rst_pending", bus.pending, m_pend_vec(), 4'b0000);
    lit("rst_req",     req_vec(),   m_req_vec(),  4'b0000);
    lit("rst_dir",     {3'd0, bus.dir_up}, {3'd0, m_dir}, 4'b0001);
    rst = 1'b0;

    // press third from ground
    set_btn(4'b1000); step(1); set_btn(4'd0); step(2);
    lit("t1_pending", bus.pending, m_pend_vec(), 4'b1000);
    lit("t1_req_pre", req_vec(),   m_req_vec(),  4'b0000);
    step(1);
    lit("t1_req",  req_vec(), m_req_vec(), 4'b1000);
    lit("t1_busy", {3'd0, bus.busy}, {3'd0, m_mode != M_IDLE}, 4'b0001);

    // nearer call on the way up, then dwell there
    set_btn(4'b0010); step(1); set_btn(4'd0); step(3);
    lit("t2_req1",  req_vec(),   m_req_vec(),  4'b0010);
    lit("t2_pend",  bus.pending, m_pend_vec(), 4'b1010);
    set_at(4'b0010); step(1);
    lit("t2_dwpend", bus.pending, m_pend_vec(), 4'b1000);
    step(7);
    lit("t2_dwreq",  req_vec(), m_req_vec(), 4'b0010);
    step(1);
    lit("t2_resume", req_vec(), m_req_vec(), 4'b1000);
    set_at(4'b1000); step(12);
    lit("t2_idle",  {3'd0, bus.busy}, {3'd0, m_mode != M_IDLE}, 4'b0000);

    // car at 2, calls at 0 and 3: up is nearer
    rst = 1'b1; set_at(4'b0100); step(1); rst = 1'b0;
    set_btn(4'b1001); step(1); set_btn(4'd0); step(3);
    lit("t3_req", req_vec(), m_req_vec(), 4'b1000);
    lit("t3_dir", {3'd0, bus.dir_up}, {3'd0, m_dir}, 4'b0001);

    // car at 1, calls at 0 and 3: down is nearer
    rst = 1'b1; set_at(4'b0010); step(1); rst = 1'b0;
    set_btn(4'b1001); step(1); set_btn(4'd0); step(3);
    lit("t4_req", req_vec(), m_req_vec(), 4'b0001);
    lit("t4_dir", {3'd0, bus.dir_up}, {3'd0, m_dir}, 4'b0000);

    // own-floor press during dwell is dropped, later press is captured
    rst = 1'b1; set_at(4'b0100); step(1); rst = 1'b0;
    set_btn(4'b0100); step(1); set_btn(4'd0); step(3);
    lit("t5_dwreq", req_vec(), m_req_vec(), 4'b0100);
    set_btn(4'b0100); step(6);
    lit("t5_drop", bus.pending, m_pend_vec(), 4'b0000);
    set_btn(4'd0); step(8);
    lit("t5_idle", {3'd0, bus.busy}, {3'd0, m_mode != M_IDLE}, 4'b0000);
    set_btn(4'b0100); step(1); set_btn(4'd0); step(2);
    lit("t5_recap", bus.pending, m_pend_vec(), 4'b0100);

    // reset in the middle of a dwell with calls pending
    rst = 1'b1; set_at(4'b0100); step(1); rst = 1'b0;
    set_btn(4'b0100); step(1); set_btn(4'd0); step(3);
    set_btn(4'b1011); step(1); set_btn(4'd0); step(2);
    lit("t6_pend", bus.pending, m_pend_vec(), 4'b1011);
    rst = 1'b1; step(1);
    lit("t6_pend0", bus.pending, m_pend_vec(), 4'b0000);
    lit("t6_req0",  req_vec(),   m_req_vec(),  4'b0000);
    lit("t6_busy0", {3'd0, bus.busy},   {3'd0, m_mode != M_IDLE}, 4'b0000);
    lit("t6_dir1",  {3'd0, bus.dir_up}, {3'd0, m_dir}, 4'b0001);
    rst = 1'b0;

    // random traffic with a car that moves one floor every 3 cycles
    car = 2; mv = 0; btn_lvl = 4'd0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst = ($urandom_range(0, 399) == 0);
      for (int f = 0; f < 4; f++)
        if ($urandom_range(0, 11) == 0) btn_lvl[f] = ~btn_lvl[f];
      set_btn(btn_lvl);
      tgt = -1;
      for (int f = 0; f < 4; f++) if (req_vec()[f]) tgt = f;
      if (tgt >= 0 && tgt != car) begin
        mv++;
        if (mv >= 3) begin
          mv = 0;
          car = (tgt > car) ? car + 1 : car - 1;
        end
      end else mv = 0;
      if ($urandom_range(0, 29) == 0) set_at(4'($urandom_range(0, 15)));
      else set_at(4'(1 << car));
      step(1);
      if (cyc % 500 == 0)
        $display("rand cyc=%0d car=%0d req=%b pending=%b", cyc, car, req_vec(), bus.pending);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
